// File: rtl/spi_slave_shift_core_pkg.sv
// Shared definitions for the SPI slave shift core: FSM states and defaults.
package spi_slave_shift_core_pkg;

    typedef enum logic {
        SPI_ST_IDLE   = 1'b0,
        SPI_ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int unsigned SPI_DEF_DATA_W  = 8;
    localparam logic [7:0]  SPI_DEF_TX_IDLE = 8'hFF;

endpackage

// File: rtl/spi_slave_shift_core.sv
// SPI mode-0 slave datapath: deserializes MOSI into words and serializes a
// one-word TX buffer onto MISO, driven by clk-domain SCLK edge pulses.
module spi_slave_shift_core
    import spi_slave_shift_core_pkg::*;
#(
    parameter int unsigned       DATA_W    = SPI_DEF_DATA_W,
    parameter bit                MSB_FIRST = 1'b1,
    parameter logic [DATA_W-1:0] TX_IDLE   = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n_sync,
    input  logic              sclk_re,
    input  logic              sclk_fe,
    input  logic              mosi_sync,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic              cs_prev;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_buf;
    logic              tx_full;
    logic [DATA_W-1:0] load_word;

    logic start, active, re_act, fe_act, last_bit, word_done, abort;
    logic tx_load, tx_step, rx_hs;

    // Frame and edge qualification. A falling edge coinciding with a rising
    // edge, or arriving while CS is already deasserted, is ignored.
    always_comb begin
        active    = (state_q == SPI_ST_ACTIVE);
        start     = (state_q == SPI_ST_IDLE) && cs_prev && !cs_n_sync;
        re_act    = active && sclk_re;
        fe_act    = active && sclk_fe && !sclk_re && !cs_n_sync;
        last_bit  = (bit_cnt == LAST_CNT);
        word_done = re_act && last_bit;
        abort     = active && cs_n_sync;
        tx_load   = start || (fe_act && (bit_cnt == '0));
        tx_step   = fe_act && (bit_cnt != '0);
        rx_hs     = rx_valid && rx_ready;
        load_word = tx_full ? tx_buf : TX_IDLE;
        cnt_next  = bit_cnt;
        if (re_act) begin
            cnt_next = last_bit ? '0 : bit_cnt + 1'b1;
        end
        if (MSB_FIRST) begin
            rx_next = {rx_shift[DATA_W-2:0], mosi_sync};
        end else begin
            rx_next = {mosi_sync, rx_shift[DATA_W-1:1]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SPI_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: frame opens on a CS falling edge, closes when CS is high.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SPI_ST_IDLE:   if (start)     state_d = SPI_ST_ACTIVE;
            SPI_ST_ACTIVE: if (cs_n_sync) state_d = SPI_ST_IDLE;
            default:                      state_d = SPI_ST_IDLE;
        endcase
    end

    // Bit counter and RX deserializer; a word completing in the CS-rise
    // cycle is still delivered because the abort only clears what is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev     <= 1'b1;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
            miso_oe     <= 1'b0;
        end else begin
            cs_prev     <= cs_n_sync;
            frame_abort <= 1'b0;
            if (re_act) begin
                rx_shift <= rx_next;
            end
            bit_cnt <= cnt_next;
            if (word_done) begin
                rx_data    <= rx_next;
                rx_valid   <= 1'b1;
                rx_overrun <= !rx_hs && (rx_valid || rx_overrun);
            end else if (rx_hs) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (start) begin
                miso_oe <= 1'b1;
            end
            if (abort) begin
                bit_cnt     <= '0;
                rx_shift    <= '0;
                miso_oe     <= 1'b0;
                frame_abort <= (cnt_next != '0);
            end
        end
    end

    // TX buffer and serializer: words load at frame start and word
    // boundaries; an empty buffer substitutes TX_IDLE and flags underrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_shift    <= '0;
            miso        <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (abort) begin
                tx_shift <= '0;
                miso     <= 1'b0;
            end else if (tx_load) begin
                tx_full     <= 1'b0;
                tx_underrun <= !tx_full;
                if (MSB_FIRST) begin
                    miso     <= load_word[DATA_W-1];
                    tx_shift <= load_word << 1;
                end else begin
                    miso     <= load_word[0];
                    tx_shift <= load_word >> 1;
                end
            end else if (tx_step) begin
                if (MSB_FIRST) begin
                    miso     <= tx_shift[DATA_W-1];
                    tx_shift <= tx_shift << 1;
                end else begin
                    miso     <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                end
            end
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    assign tx_ready = !tx_full;

endmodule

// File: tb/tb_spi_slave_shift_core.sv
// Self-checking bench for spi_slave_shift_core: cycle-level behavioural model
// plus directed literal checks and randomized frames.
module tb_spi_slave_shift_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       cs_n = 1'b1, sclk_re = 1'b0, sclk_fe = 1'b0, mosi = 1'b0;
    logic       rx_ready = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, rx_valid, rx_overrun, tx_ready, tx_underrun, frame_abort;
    logic [7:0] rx_data;

    logic        cs2 = 1'b1, re2 = 1'b0, fe2 = 1'b0, mosi2 = 1'b0;
    logic        miso2, oe2, rx_valid2, ovr2, tx_ready2, under2, abort2;
    logic [15:0] rx_data2;

    spi_slave_shift_core dut (
        .clk(clk), .rst_n(rst_n), .cs_n_sync(cs_n), .sclk_re(sclk_re), .sclk_fe(sclk_fe),
        .mosi_sync(mosi), .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    spi_slave_shift_core #(.DATA_W(16), .MSB_FIRST(1'b0), .TX_IDLE(16'hFFFF)) dut16 (
        .clk(clk), .rst_n(rst_n), .cs_n_sync(cs2), .sclk_re(re2), .sclk_fe(fe2),
        .mosi_sync(mosi2), .miso(miso2), .miso_oe(oe2), .rx_data(rx_data2),
        .rx_valid(rx_valid2), .rx_ready(1'b0), .rx_overrun(ovr2),
        .tx_data(16'h0000), .tx_valid(1'b0), .tx_ready(tx_ready2),
        .tx_underrun(under2), .frame_abort(abort2)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (bit-index view of the link) -------------
    logic       m_active, m_cs_prev, m_rx_valid, m_ovr, m_full, m_miso, m_oe, m_under, m_abort;
    logic       m_hs, m_take, m_done;
    logic [7:0] m_acc, m_rx_data, m_buf, m_word;
    int         m_n, m_idx;

    task automatic m_load();
        if (m_full) begin
            m_word = m_buf;
            m_full = 1'b0;
        end else begin
            m_word  = 8'hFF;
            m_under = 1'b1;
        end
        m_idx  = 0;
        m_miso = m_word[7];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_cs_prev = 1; m_n = 0; m_idx = 0; m_acc = '0; m_rx_data = '0;
            m_rx_valid = 0; m_ovr = 0; m_full = 0; m_buf = '0; m_word = '0;
            m_miso = 0; m_oe = 0; m_under = 0; m_abort = 0;
        end else begin
            m_hs = m_rx_valid && rx_ready;
            m_take = tx_valid && !m_full;
            m_done = 0; m_under = 0; m_abort = 0;
            if (!m_active) begin
                if (m_cs_prev && !cs_n) begin
                    m_active = 1; m_oe = 1;
                    m_load();
                end
            end else begin
                if (sclk_re) begin
                    m_acc[7-m_n] = mosi;
                    m_n++;
                    if (m_n == 8) begin m_done = 1; m_n = 0; end
                end else if (sclk_fe && !cs_n) begin
                    if (m_n == 0) m_load();
                    else begin m_idx++; m_miso = m_word[7-m_idx]; end
                end
                if (cs_n) begin
                    m_active = 0; m_oe = 0; m_miso = 0;
                    m_abort = (m_n != 0); m_n = 0;
                end
            end
            if (m_done) begin
                m_rx_data = m_acc;
                m_ovr = !m_hs && (m_rx_valid || m_ovr);
                m_rx_valid = 1;
            end else if (m_hs) begin
                m_rx_valid = 0; m_ovr = 0;
            end
            if (m_take) begin m_buf = tx_data; m_full = 1; end
            m_cs_prev = cs_n;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic cmp_en = 1'b0;
    int   under_cnt = 0, abort_cnt = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("miso", miso, m_miso);
            chk("miso_oe", miso_oe, m_oe);
            chk("rx_valid", rx_valid, m_rx_valid);
            chk("rx_data", rx_data, m_rx_data);
            chk("rx_overrun", rx_overrun, m_ovr);
            chk("tx_ready", tx_ready, !m_full);
            chk("tx_underrun", tx_underrun, m_under);
            chk("frame_abort", frame_abort, m_abort);
            if (tx_underrun) under_cnt++;
            if (frame_abort) abort_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            rx_ready = 1'($urandom_range(0, 1));
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
        end
    endtask

    task automatic cs_fall();
        cs_n = 1'b0; tick(); tick();
    endtask

    task automatic cs_rise();
        cs_n = 1'b1; tick(); tick();
    endtask

    task automatic handshake();
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    endtask

    // One word (or nbits of it), MSB first; captures MISO as a master would at each rise.
    task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            mi[7-i] = miso;
            sclk_re = 1'b1; tick(); sclk_re = 1'b0;
            sclk_fe = 1'b1; tick(); sclk_fe = 1'b0;
            tick();
        end
    endtask

    task automatic xfer_rnd(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            sclk_re = 1'b1;
            sclk_fe = ($urandom_range(0, 9) == 0);
            tick();
            sclk_re = 1'b0;
            sclk_fe = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            sclk_fe = 1'b1; tick(); sclk_fe = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_overrun", rx_overrun, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_tx_underrun", tx_underrun, 1'b0);
        chk("rst_frame_abort", frame_abort, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] mi, mi2;
        logic [15:0] w16;
        int u0, a0;

        #2 rst_n = 1'b0;
        tick(); tick();
        chk_reset_vals();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // 1: receive 0xA5
        cs_fall();
        xfer(8'hA5, 8, mi);
        chk("t1_rx_data", rx_data, 8'hA5);
        chk("t1_rx_valid", rx_valid, 1'b1);
        cs_rise();
        handshake();
        tick();
        chk("t1_rx_cleared", rx_valid, 1'b0);

        // 2: preloaded 0x3C appears on MISO
        tx_data = 8'h3C; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        chk("t2_tx_ready_full", tx_ready, 1'b0);
        cs_fall();
        chk("t2_tx_ready_after_load", tx_ready, 1'b1);
        xfer(8'h96, 8, mi);
        chk("t2_miso_word", mi, 8'h3C);
        cs_rise();
        handshake();

        // 3: back-to-back words with no consumer -> overrun
        cs_fall();
        xfer(8'h11, 8, mi);
        xfer(8'h22, 8, mi);
        chk("t3_rx_data", rx_data, 8'h22);
        chk("t3_overrun", rx_overrun, 1'b1);
        cs_rise();
        handshake();
        tick();
        chk("t3_valid_clr", rx_valid, 1'b0);
        chk("t3_overrun_clr", rx_overrun, 1'b0);

        // 4: underrun on first word, buffered 0x5A on second
        u0 = under_cnt;
        cs_fall();
        chk("t4_underrun_pulse", under_cnt - u0, 1);
        tx_data = 8'h5A; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
        xfer(8'h00, 8, mi);
        xfer(8'h00, 8, mi2);
        chk("t4_idle_word", mi, 8'hFF);
        chk("t4_second_word", mi2, 8'h5A);
        cs_rise();
        handshake();

        // 5: abort after 5 bits, then clean 0x81
        a0 = abort_cnt;
        cs_fall();
        xfer(8'hF0, 5, mi);
        cs_rise();
        chk("t5_abort_pulse", abort_cnt - a0, 1);
        chk("t5_no_valid", rx_valid, 1'b0);
        cs_fall();
        xfer(8'h81, 8, mi);
        cs_rise();
        chk("t5_rx_data", rx_data, 8'h81);
        handshake();

        // 5b: CS rises on the completing rise edge -> word kept, no abort
        a0 = abort_cnt;
        cs_fall();
        xfer(8'hC3, 7, mi);
        mosi = 1'b1; sclk_re = 1'b1; cs_n = 1'b1; tick(); sclk_re = 1'b0;
        tick(); tick();
        chk("t5b_rx_data", rx_data, 8'hC3);
        chk("t5b_rx_valid", rx_valid, 1'b1);
        chk("t5b_no_abort", abort_cnt - a0, 0);
        handshake();

        // 6: reset mid-word, then clean 0x7E
        cs_fall();
        xfer(8'hAA, 3, mi);
        #2 rst_n = 1'b0; cs_n = 1'b1;
        #1 chk_reset_vals();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        cs_fall();
        xfer(8'h7E, 8, mi);
        cs_rise();
        chk("t6_rx_data", rx_data, 8'h7E);
        handshake();

        // randomized frames against the model
        rnd = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            cs_fall();
            for (int k = 0; k < nw; k++) begin
                int nb;
                nb = 8;
                if (k == nw - 1 && $urandom_range(0, 3) == 0) nb = $urandom_range(1, 7);
                xfer_rnd(8'($urandom), nb);
            end
            cs_rise();
        end
        rnd = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        tick();

        // 7: 16-bit LSB-first instance receives 0x1234
        w16 = 16'h1234;
        cs2 = 1'b0; tick(); tick();
        for (int i = 0; i < 16; i++) begin
            mosi2 = w16[i];
            re2 = 1'b1; tick(); re2 = 1'b0;
            fe2 = 1'b1; tick(); fe2 = 1'b0;
        end
        cs2 = 1'b1; tick(); tick();
        chk("t7_rx_data16", rx_data2, 16'h1234);
        chk("t7_rx_valid16", rx_valid2, 1'b1);
        chk("t7_no_abort16", abort2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
